// File: rtl/pe_fu_issue.sv
// Operand staging and result register around one PE functional unit.
// Contents: the pe_types package, a combinational FU (ALU or multiplier),
// and the pe_fu_issue wrapper. The wrapper buffers A/B operands in small
// FIFOs, selects an optional constant B, fires the FU and registers the result.

package pe_types;
    typedef enum logic [3:0] {
        FU_ADD    = 4'd0,
        FU_SUB    = 4'd1,
        FU_AND    = 4'd2,
        FU_OR     = 4'd3,
        FU_XOR    = 4'd4,
        FU_SLL    = 4'd5,
        FU_SRL    = 4'd6,
        FU_PASS_A = 4'd7,
        FU_MUL    = 4'd8,
        FU_MULH   = 4'd9
    } fu_func;
endpackage

// Purely combinational functional unit; results are the low 32 bits except MULH.
module pe_fu
    import pe_types::*;
#(
    parameter int unsigned IS_MUL = 0
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  fu_func      op,
    output logic [31:0] y
);
    logic [63:0] prod_s;

    // Select the FU result for the configured operation.
    always_comb begin
        prod_s = {32'd0, a} * {32'd0, b};
        y      = 32'd0;
        if (IS_MUL != 0) begin
            case (op)
                FU_MUL:  y = prod_s[31:0];
                FU_MULH: y = prod_s[63:32];
                default: y = 32'd0;
            endcase
        end else begin
            case (op)
                FU_ADD:    y = a + b;
                FU_SUB:    y = a - b;
                FU_AND:    y = a & b;
                FU_OR:     y = a | b;
                FU_XOR:    y = a ^ b;
                FU_SLL:    y = a << b[4:0];
                FU_SRL:    y = a >> b[4:0];
                FU_PASS_A: y = a;
                default:   y = 32'd0;
            endcase
        end
    end
endmodule

module pe_fu_issue
    import pe_types::*;
#(
    parameter int unsigned IS_MUL = 0,
    parameter int          DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              in_a_data,
    input  logic                     in_a_valid,
    output logic                     in_a_ready,
    input  logic [31:0]              in_b_data,
    input  logic                     in_b_valid,
    output logic                     in_b_ready,
    input  logic                     cfg_we,
    input  fu_func                   cfg_op,
    input  logic                     cfg_b_const,
    input  logic [31:0]              cfg_const,
    output logic [31:0]              res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(DEPTH):0]   a_count,
    output logic [$clog2(DEPTH):0]   b_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   a_mem_r [DEPTH];
    logic [31:0]   b_mem_r [DEPTH];
    logic [PW-1:0] a_wr_ptr_r, a_rd_ptr_r, b_wr_ptr_r, b_rd_ptr_r;
    logic [CW-1:0] a_cnt_r, b_cnt_r;

    fu_func        op_r;
    logic          b_const_r;
    logic [31:0]   const_r;

    logic [31:0]   res_data_r;
    logic          res_valid_r;

    logic          a_ready_s, b_ready_s;
    logic          a_push_s, b_push_s, a_pop_s, b_pop_s, fire_s;
    logic [31:0]   a_op_s, b_op_s, fu_y_s;

    // Handshake, fire and operand selection derived from registered state.
    always_comb begin
        a_ready_s = (a_cnt_r != CW'(DEPTH));
        b_ready_s = (b_cnt_r != CW'(DEPTH));
        a_push_s  = in_a_valid && a_ready_s;
        b_push_s  = in_b_valid && b_ready_s;
        fire_s    = (a_cnt_r != {CW{1'b0}}) &&
                    (b_const_r || (b_cnt_r != {CW{1'b0}})) &&
                    (!res_valid_r || res_ready);
        a_pop_s   = fire_s;
        b_pop_s   = fire_s && !b_const_r;
        a_op_s    = a_mem_r[a_rd_ptr_r];
        if (b_const_r) begin
            b_op_s = const_r;
        end else begin
            b_op_s = b_mem_r[b_rd_ptr_r];
        end
    end

    pe_fu #(.IS_MUL(IS_MUL)) u_fu (
        .a  (a_op_s),
        .b  (b_op_s),
        .op (op_r),
        .y  (fu_y_s)
    );

    // Operand A FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) a_mem_r[i] <= 32'd0;
            a_wr_ptr_r <= {PW{1'b0}};
            a_rd_ptr_r <= {PW{1'b0}};
            a_cnt_r    <= {CW{1'b0}};
        end else begin
            if (a_push_s) begin
                a_mem_r[a_wr_ptr_r] <= in_a_data;
                a_wr_ptr_r          <= a_wr_ptr_r + PW'(1);
            end
            if (a_pop_s) a_rd_ptr_r <= a_rd_ptr_r + PW'(1);
            case ({a_push_s, a_pop_s})
                2'b10:   a_cnt_r <= a_cnt_r + CW'(1);
                2'b01:   a_cnt_r <= a_cnt_r - CW'(1);
                default: a_cnt_r <= a_cnt_r;
            endcase
        end
    end

    // Operand B FIFO storage, pointers and occupancy; never popped in const mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) b_mem_r[i] <= 32'd0;
            b_wr_ptr_r <= {PW{1'b0}};
            b_rd_ptr_r <= {PW{1'b0}};
            b_cnt_r    <= {CW{1'b0}};
        end else begin
            if (b_push_s) begin
                b_mem_r[b_wr_ptr_r] <= in_b_data;
                b_wr_ptr_r          <= b_wr_ptr_r + PW'(1);
            end
            if (b_pop_s) b_rd_ptr_r <= b_rd_ptr_r + PW'(1);
            case ({b_push_s, b_pop_s})
                2'b10:   b_cnt_r <= b_cnt_r + CW'(1);
                2'b01:   b_cnt_r <= b_cnt_r - CW'(1);
                default: b_cnt_r <= b_cnt_r;
            endcase
        end
    end

    // Configuration registers; a same-cycle fire still sees the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= fu_func'(4'd0);
            b_const_r <= 1'b0;
            const_r   <= 32'd0;
        end else if (cfg_we) begin
            op_r      <= cfg_op;
            b_const_r <= cfg_b_const;
            const_r   <= cfg_const;
        end
    end

    // Result register: load on fire, drop valid when consumed, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_r  <= 32'd0;
            res_valid_r <= 1'b0;
        end else if (fire_s) begin
            res_data_r  <= fu_y_s;
            res_valid_r <= 1'b1;
        end else if (res_ready) begin
            res_valid_r <= 1'b0;
        end
    end

    assign in_a_ready = a_ready_s;
    assign in_b_ready = b_ready_s;
    assign res_data   = res_data_r;
    assign res_valid  = res_valid_r;
    assign a_count    = a_cnt_r;
    assign b_count    = b_cnt_r;
endmodule

// File: tb/tb_pe_fu_issue.sv
// Self-checking bench for pe_fu_issue: an ALU instance checked through a
// result scoreboard, plus a multiplier instance checked directly.
module tb_pe_fu_issue;
    import pe_types::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk, rst;
    // ALU instance signals
    logic [31:0]   in_a_data, in_b_data, cfg_const, res_data;
    logic          in_a_valid, in_a_ready, in_b_valid, in_b_ready;
    logic          cfg_we, cfg_b_const, res_valid, res_ready;
    fu_func        cfg_op;
    logic [CW-1:0] a_count, b_count;
    // Multiplier instance signals
    logic [31:0]   m_a_data, m_b_data, m_cfg_const, m_res_data;
    logic          m_a_valid, m_a_ready, m_b_valid, m_b_ready;
    logic          m_cfg_we, m_cfg_b_const, m_res_valid, m_res_ready;
    fu_func        m_cfg_op;
    logic [CW-1:0] m_a_count, m_b_count;

    int            errors = 0;
    int            checks = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   exp_v;
    logic [31:0]   av [3] = '{32'd3, 32'd4, 32'd9};

    pe_fu_issue #(.IS_MUL(0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_a_data(in_a_data), .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
        .in_b_data(in_b_data), .in_b_valid(in_b_valid), .in_b_ready(in_b_ready),
        .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_b_const(cfg_b_const), .cfg_const(cfg_const),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .a_count(a_count), .b_count(b_count)
    );

    pe_fu_issue #(.IS_MUL(1), .DEPTH(DEPTH)) dut_mul (
        .clk(clk), .rst(rst),
        .in_a_data(m_a_data), .in_a_valid(m_a_valid), .in_a_ready(m_a_ready),
        .in_b_data(m_b_data), .in_b_valid(m_b_valid), .in_b_ready(m_b_ready),
        .cfg_we(m_cfg_we), .cfg_op(m_cfg_op), .cfg_b_const(m_cfg_b_const), .cfg_const(m_cfg_const),
        .res_data(m_res_data), .res_valid(m_res_valid), .res_ready(m_res_ready),
        .a_count(m_a_count), .b_count(m_b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input fu_func op, input logic bc, input logic [31:0] k);
        cfg_we = 1'b1; cfg_op = op; cfg_b_const = bc; cfg_const = k;
        tick();
        cfg_we = 1'b0;
    endtask

    // Scoreboard: every result handed downstream must match the queue head.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 32'(res_valid), 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                check("sb_result", res_data, exp_v);
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_a_data = 32'd0; in_a_valid = 1'b0; in_b_data = 32'd0; in_b_valid = 1'b0;
        cfg_we = 1'b0; cfg_op = FU_ADD; cfg_b_const = 1'b0; cfg_const = 32'd0; res_ready = 1'b0;
        m_a_data = 32'd0; m_a_valid = 1'b0; m_b_data = 32'd0; m_b_valid = 1'b0;
        m_cfg_we = 1'b0; m_cfg_op = FU_ADD; m_cfg_b_const = 1'b0; m_cfg_const = 32'd0;
        m_res_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_a_count", 32'(a_count), 32'd0);
        check("rst_b_count", 32'(b_count), 32'd0);
        check("rst_a_ready", 32'(in_a_ready), 32'd1);
        check("rst_b_ready", 32'(in_b_ready), 32'd1);

        // ALU add: 5 + 7
        cfg(FU_ADD, 1'b0, 32'd0);
        res_ready = 1'b1;
        in_a_valid = 1'b1; in_a_data = 32'd5; in_b_valid = 1'b1; in_b_data = 32'd7;
        exp_q.push_back(32'd12);
        tick();
        in_a_valid = 1'b0; in_b_valid = 1'b0;
        check("add_not_yet", 32'(res_valid), 32'd0);
        tick();
        check("add_valid", 32'(res_valid), 32'd1);
        check("add_data", res_data, 32'd12);
        tick();
        check("add_valid_drop", 32'(res_valid), 32'd0);

        // Backpressure fills the FIFOs
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a_valid = 1'b1; in_a_data = av[i]; in_b_valid = 1'b1; in_b_data = 32'd1;
            exp_q.push_back(av[i] + 32'd1);
            tick();
        end
        in_a_valid = 1'b0; in_b_valid = 1'b0;
        check("bp_a_count", 32'(a_count), 32'd2);
        check("bp_b_count", 32'(b_count), 32'd2);
        check("bp_a_ready", 32'(in_a_ready), 32'd0);
        check("bp_b_ready", 32'(in_b_ready), 32'd0);
        check("bp_valid", 32'(res_valid), 32'd1);
        repeat (3) tick();
        check("bp_hold_data", res_data, 32'd4);
        check("bp_hold_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        repeat (4) tick();
        check("bp_drained_valid", 32'(res_valid), 32'd0);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        check("bp_a_count_end", 32'(a_count), 32'd0);

        // Constant B mode
        cfg(FU_ADD, 1'b1, 32'd100);
        for (int i = 0; i < 3; i++) begin
            in_a_valid = 1'b1; in_a_data = 32'(i + 1);
            in_b_valid = (i == 0); in_b_data = 32'd8;
            exp_q.push_back(32'(101 + i));
            tick();
            check("const_b_count", 32'(b_count), 32'd1);
        end
        in_a_valid = 1'b0; in_b_valid = 1'b0;
        repeat (3) tick();
        check("const_b_count_end", 32'(b_count), 32'd1);
        check("const_a_count_end", 32'(a_count), 32'd0);
        check("const_sb_empty", 32'(exp_q.size()), 32'd0);

        // Multiplier instance
        m_cfg_we = 1'b1; m_cfg_op = FU_MUL; m_cfg_b_const = 1'b0; m_cfg_const = 32'd0;
        tick();
        m_cfg_we = 1'b0;
        m_res_ready = 1'b1;
        m_a_valid = 1'b1; m_a_data = 32'hFFFF_FFFF; m_b_valid = 1'b1; m_b_data = 32'd2;
        tick();
        m_a_valid = 1'b0; m_b_valid = 1'b0;
        tick();
        check("mul_valid", 32'(m_res_valid), 32'd1);
        check("mul_data", m_res_data, 32'hFFFF_FFFE);
        tick();
        check("mul_valid_drop", 32'(m_res_valid), 32'd0);
        m_a_valid = 1'b1; m_a_data = 32'd3;
        tick();
        m_a_valid = 1'b0;
        repeat (3) tick();
        check("mul_no_b_valid", 32'(m_res_valid), 32'd0);
        check("mul_no_b_a_count", 32'(m_a_count), 32'd1);
        check("mul_no_b_b_count", 32'(m_b_count), 32'd0);

        // Reset mid-stream; B FIFO still holds 8 from const mode
        cfg(FU_ADD, 1'b0, 32'd0);
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a_valid = 1'b1; in_a_data = 32'(10 + i);
            if (i == 0) exp_q.push_back(32'd18);
            tick();
        end
        in_a_valid = 1'b0;
        check("mid_a_count", 32'(a_count), 32'd2);
        check("mid_valid", 32'(res_valid), 32'd1);
        check("mid_data", res_data, 32'd18);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_a_count", 32'(a_count), 32'd0);
        check("mid_rst_b_count", 32'(b_count), 32'd0);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_data", res_data, 32'd0);
        res_ready = 1'b1;
        repeat (4) tick();
        check("mid_no_stale", 32'(res_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
